// File: rtl/controle_chamadas.sv
// Call scheduler and door sequencer for a 4-floor elevator: latches calls, picks direction
// with a SCAN policy, strobes one-floor moves and holds the door open at each served floor.
module controle_chamadas #(
    parameter int unsigned TEMPO_VIAGEM  = 8,
    parameter int unsigned TEMPO_PORTA   = 16,
    parameter int unsigned LARGURA_TIMER = 5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] andar_atual,
    input  logic [3:0] botoes,
    output logic       controle_subida_descida,
    output logic       mover,
    output logic       porta_aberta,
    output logic [3:0] chamadas_pendentes,
    output logic [1:0] estado
);

    localparam int unsigned NUM_ANDARES = 4;
    localparam logic [LARGURA_TIMER-1:0] RECARGA_VIAGEM = LARGURA_TIMER'(TEMPO_VIAGEM - 1);
    localparam logic [LARGURA_TIMER-1:0] RECARGA_PORTA  = LARGURA_TIMER'(TEMPO_PORTA - 1);

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        VIAJANDO = 2'b01,
        CHEGADA  = 2'b10,
        PORTA    = 2'b11
    } estado_t;

    estado_t                  estado_q, estado_d;
    logic [NUM_ANDARES-1:0]   pend_q, pend_d;
    logic                     dir_q, dir_d;
    logic [LARGURA_TIMER-1:0] timer_q, timer_d;
    logic                     mover_q, mover_d;
    logic                     porta_q, porta_d;

    logic                     acima, abaixo, aqui, frente, tras;
    logic [NUM_ANDARES-1:0]   limpa;

    // Pending calls relative to the current floor
    always_comb begin
        acima  = 1'b0;
        abaixo = 1'b0;
        for (int unsigned i = 0; i < NUM_ANDARES; i++) begin
            if (2'(i) > andar_atual) acima  = acima  | pend_q[i];
            if (2'(i) < andar_atual) abaixo = abaixo | pend_q[i];
        end
        aqui   = pend_q[andar_atual];
        frente = dir_q ? acima  : abaixo;
        tras   = dir_q ? abaixo : acima;
    end

    // Next-state, timer and call-clear decode
    always_comb begin
        estado_d = estado_q;
        dir_d    = dir_q;
        timer_d  = timer_q;
        limpa    = '0;

        unique case (estado_q)
            OCIOSO, CHEGADA: begin
                if (aqui) begin
                    limpa    = 4'b0001 << andar_atual;
                    estado_d = PORTA;
                    timer_d  = RECARGA_PORTA;
                end else if (frente) begin
                    estado_d = VIAJANDO;
                    timer_d  = RECARGA_VIAGEM;
                end else if (tras) begin
                    dir_d    = ~dir_q;
                    estado_d = VIAJANDO;
                    timer_d  = RECARGA_VIAGEM;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            VIAJANDO: begin
                if (timer_q == '0) begin
                    estado_d = CHEGADA;
                end else begin
                    timer_d = timer_q - LARGURA_TIMER'(1);
                end
            end
            PORTA: begin
                // A fresh call at the open floor is absorbed by re-holding the door
                if (aqui) begin
                    limpa   = 4'b0001 << andar_atual;
                    timer_d = RECARGA_PORTA;
                end else if (timer_q == '0) begin
                    estado_d = OCIOSO;
                end else begin
                    timer_d = timer_q - LARGURA_TIMER'(1);
                end
            end
            default: estado_d = OCIOSO;
        endcase

        pend_d  = (pend_q | botoes) & ~limpa;
        mover_d = (estado_d == VIAJANDO) && (timer_d == '0);
        porta_d = (estado_d == PORTA);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
            pend_q   <= '0;
            dir_q    <= 1'b1;
            timer_q  <= '0;
            mover_q  <= 1'b0;
            porta_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pend_q   <= pend_d;
            dir_q    <= dir_d;
            timer_q  <= timer_d;
            mover_q  <= mover_d;
            porta_q  <= porta_d;
        end
    end

    assign controle_subida_descida = dir_q;
    assign mover                   = mover_q;
    assign porta_aberta            = porta_q;
    assign chamadas_pendentes      = pend_q;
    assign estado                  = estado_q;

endmodule
